decode_stage: RTL and testbench

//  RV32I decode stage between fetch and execute; sole consumer of the register file read ports.
//  - Splits instruction fields and drives rs1/rs2 to the register file.
//  - Generates immediates and runs a per-register scoreboard for RAW/WAW stalls.
//  - Captures operands into a single ID/EX output register with valid/ready handshakes on both sides.

---
 rtl/rv32_pkg.sv | 32 +++
 rtl/decode_stage_if.sv | 36 +++
 rtl/decode_stage_imm_gen.sv | 27 ++
 rtl/decode_stage.sv | 121 ++++++++++++
 tb/tb_decode_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// RV32I decode constants: opcodes, immediate formats and the opcode->format map.
package rv32_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = $clog2(NREG);

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } imm_fmt_e;

  function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
    case (opc)
      OP:                   return FMT_R;
      OP_IMM, LOAD, JALR:   return FMT_I;
      STORE:                return FMT_S;
      BRANCH:               return FMT_B;
      LUI, AUIPC:           return FMT_U;
      JAL:                  return FMT_J;
      default:              return FMT_NONE;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// Fetch / register-file / write-back / execute signals of the decode stage.
interface decode_stage_if
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = rv32_pkg::XLEN
) ();
  logic             ifValid, ifReady;
  logic [31:0]      ifInstr;
  logic [XLEN-1:0]  ifPc;
  logic [REG_W-1:0] rs1, rs2;
  logic [XLEN-1:0]  readData1, readData2;
  logic             wbValid, wbRegWrite;
  logic [REG_W-1:0] wbRd;
  logic [XLEN-1:0]  wbData;
  logic             flush;
  logic             exValid, exReady;
  logic [XLEN-1:0]  exPc, exRs1Val, exRs2Val, exImm;
  logic [REG_W-1:0] exRd;
  logic [6:0]       exOpcode;
  logic [2:0]       exFunct3;
  logic             exFunct7b5, exRegWrite, exMemRead;

  modport master (
    output ifValid, ifInstr, ifPc, readData1, readData2,
           wbValid, wbRegWrite, wbRd, wbData, flush, exReady,
    input  ifReady, rs1, rs2, exValid, exPc, exRs1Val, exRs2Val, exImm,
           exRd, exOpcode, exFunct3, exFunct7b5, exRegWrite, exMemRead
  );

  modport slave (
    input  ifValid, ifInstr, ifPc, readData1, readData2,
           wbValid, wbRegWrite, wbRd, wbData, flush, exReady,
    output ifReady, rs1, rs2, exValid, exPc, exRs1Val, exRs2Val, exImm,
           exRd, exOpcode, exFunct3, exFunct7b5, exRegWrite, exMemRead
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: instruction -> {format, sign-extended immediate}.
module imm_gen
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = rv32_pkg::XLEN
) (
  input  logic [31:0]     i_instr,
  output imm_fmt_e        o_fmt,
  output logic [XLEN-1:0] o_imm
);
  logic [31:0] w_imm32;

  always_comb begin
    o_fmt = fmt_of(i_instr[6:0]);
    case (o_fmt)
      FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {i_instr[31:12], 12'h000};
      FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
    o_imm = XLEN'($signed(w_imm32));
  end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field split, RAW/WAW scoreboard, single ID/EX output register.
// Optional write-back operand bypass: define DECODE_WB_BYPASS_EN.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = rv32_pkg::XLEN
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  logic [6:0]       w_opcode;
  logic [REG_W-1:0] w_rd, w_rs1, w_rs2;
  imm_fmt_e         w_fmt;
  logic [XLEN-1:0]  w_imm, w_op1, w_op2;
  logic             w_use_rs1, w_use_rs2, w_writes_rd;
  logic             w_byp1, w_byp2, w_stall, w_accept;
  logic [NREG-1:0]  w_pending_nxt;

  logic [NREG-1:0]  r_pending;
  logic             r_ex_valid, r_ex_regwrite, r_ex_memread, r_ex_f7b5;
  logic [XLEN-1:0]  r_ex_pc, r_ex_rs1, r_ex_rs2, r_ex_imm;
  logic [REG_W-1:0] r_ex_rd;
  logic [6:0]       r_ex_opcode;
  logic [2:0]       r_ex_f3;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (bus.ifInstr),
    .o_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  assign w_opcode = bus.ifInstr[6:0];
  assign w_rd     = bus.ifInstr[11:7];
  assign w_rs1    = bus.ifInstr[19:15];
  assign w_rs2    = bus.ifInstr[24:20];
  assign bus.rs1  = w_rs1;
  assign bus.rs2  = w_rs2;

  // Unknown opcodes (FMT_NONE) still count as rs1 users but never write rd.
  assign w_use_rs1   = !(w_fmt inside {FMT_U, FMT_J});
  assign w_use_rs2   = w_fmt inside {FMT_R, FMT_S, FMT_B};
  assign w_writes_rd = (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (w_rd != '0);

`ifdef DECODE_WB_BYPASS_EN
  assign w_byp1 = bus.wbValid && bus.wbRegWrite && (bus.wbRd == w_rs1) && (w_rs1 != '0);
  assign w_byp2 = bus.wbValid && bus.wbRegWrite && (bus.wbRd == w_rs2) && (w_rs2 != '0);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_op1 = (w_rs1 == '0) ? '0 : (w_byp1 ? bus.wbData : bus.readData1);
  assign w_op2 = (w_rs2 == '0) ? '0 : (w_byp2 ? bus.wbData : bus.readData2);

  assign w_stall = bus.ifValid &&
                   ((w_use_rs1 && r_pending[w_rs1] && !w_byp1) ||
                    (w_use_rs2 && r_pending[w_rs2] && !w_byp2) ||
                    (w_writes_rd && r_pending[w_rd]));
  assign bus.ifReady = !w_stall && (!r_ex_valid || bus.exReady);
  assign w_accept    = bus.ifValid && bus.ifReady;

  // Clears first, then set, so a same-index set in this cycle wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.wbValid && (bus.wbRd != '0))
      w_pending_nxt[bus.wbRd] = 1'b0;
    if (bus.flush && r_ex_valid && r_ex_regwrite)
      w_pending_nxt[r_ex_rd] = 1'b0;
    if (w_accept && !bus.flush && w_writes_rd)
      w_pending_nxt[w_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= '0;
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_imm      <= '0;
      r_ex_rd       <= '0;
      r_ex_opcode   <= '0;
      r_ex_f3       <= '0;
      r_ex_f7b5     <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (bus.flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_accept) begin
        r_ex_valid    <= 1'b1;
        r_ex_pc       <= bus.ifPc;
        r_ex_rs1      <= w_op1;
        r_ex_rs2      <= w_op2;
        r_ex_imm      <= w_imm;
        r_ex_rd       <= w_rd;
        r_ex_opcode   <= w_opcode;
        r_ex_f3       <= bus.ifInstr[14:12];
        r_ex_f7b5     <= bus.ifInstr[30];
        r_ex_regwrite <= w_writes_rd;
        r_ex_memread  <= (w_opcode == LOAD);
      end else if (bus.exReady) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign bus.exValid    = r_ex_valid;
  assign bus.exPc       = r_ex_pc;
  assign bus.exRs1Val   = r_ex_rs1;
  assign bus.exRs2Val   = r_ex_rs2;
  assign bus.exImm      = r_ex_imm;
  assign bus.exRd       = r_ex_rd;
  assign bus.exOpcode   = r_ex_opcode;
  assign bus.exFunct3   = r_ex_f3;
  assign bus.exFunct7b5 = r_ex_f7b5;
  assign bus.exRegWrite = r_ex_regwrite;
  assign bus.exMemRead  = r_ex_memread;
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; follows DECODE_WB_BYPASS_EN like the RTL.
module tb_decode_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Register file model: asynchronous read, x0 deliberately not hard-wired.
  logic [31:0] rf [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'hDEADBEEF : 32'h1000 + 32'(i);
    end else if (bus.wbValid && bus.wbRegWrite) begin
      rf[bus.wbRd] <= bus.wbData;
    end
  end
  always_comb begin
    bus.readData1 = rf[bus.rs1];
    bus.readData2 = rf[bus.rs2];
  end

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.ifValid = 1'b1; bus.ifInstr = instr; bus.ifPc = pc;
  endtask
  task automatic idle();
    bus.ifValid = 1'b0; bus.ifInstr = '0; bus.ifPc = '0;
  endtask
  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.wbValid = v; bus.wbRegWrite = v; bus.wbRd = rd; bus.wbData = d;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic retire(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clk); set_wb(1'b1, rd, d); tick();
    @(negedge clk); set_wb(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (bus.exValid !== 1'b0) $display("FAIL rst_exValid: got %0b want 0", bus.exValid); else n_pass++;
    n_total++; if (bus.exRegWrite !== 1'b0) $display("FAIL rst_exRegWrite: got %0b want 0", bus.exRegWrite); else n_pass++;
    n_total++; if (bus.exImm !== 32'h0) $display("FAIL rst_exImm: got %h want 0", bus.exImm); else n_pass++;
    n_total++; if (bus.exPc !== 32'h0) $display("FAIL rst_exPc: got %h want 0", bus.exPc); else n_pass++;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL rst_ifReady: got %0b want 1", bus.ifReady); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); bus.exReady = 1'b1; drive(32'h00500093, 32'h100); #1;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL b2b_ready0: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b1) $display("FAIL b2b_valid0: got %0b want 1", bus.exValid); else n_pass++;
    n_total++; if (bus.exImm !== 32'd5) $display("FAIL b2b_imm0: got %h want 5", bus.exImm); else n_pass++;
    n_total++; if (bus.exPc !== 32'h100) $display("FAIL b2b_pc0: got %h want 100", bus.exPc); else n_pass++;
    n_total++; if (bus.exRd !== 5'd1 || bus.exRegWrite !== 1'b1) $display("FAIL b2b_rd0: got rd=%0d we=%0b want rd=1 we=1", bus.exRd, bus.exRegWrite); else n_pass++;
    @(negedge clk); drive(32'h00700113, 32'h104); #1;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL b2b_ready1: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b1) $display("FAIL b2b_valid1: got %0b want 1", bus.exValid); else n_pass++;
    n_total++; if (bus.exImm !== 32'd7 || bus.exRd !== 5'd2) $display("FAIL b2b_imm1: got imm=%h rd=%0d want 7 rd=2", bus.exImm, bus.exRd); else n_pass++;
    @(negedge clk); idle(); tick();
    n_total++; if (bus.exValid !== 1'b0) $display("FAIL b2b_drain: got %0b want 0", bus.exValid); else n_pass++;
    retire(5'd1, 32'd5);
    retire(5'd2, 32'd7);
  endtask

  task automatic test_raw();
    @(negedge clk); drive(32'h00100193, 32'h200); tick();
    @(negedge clk); drive(32'h00318233, 32'h204); #1;
    n_total++; if (bus.rs1 !== 5'd3 || bus.rs2 !== 5'd3) $display("FAIL raw_rsaddr: got %0d,%0d want 3,3", bus.rs1, bus.rs2); else n_pass++;
    n_total++; if (bus.ifReady !== 1'b0) $display("FAIL raw_stall: got %0b want 0", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b0) $display("FAIL raw_bubble: got %0b want 0", bus.exValid); else n_pass++;
    @(negedge clk); set_wb(1'b1, 5'd3, 32'h11); #1;
`ifdef DECODE_WB_BYPASS_EN
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL raw_byp_ready: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b1 || bus.exRd !== 5'd4) $display("FAIL raw_byp_issue: got v=%0b rd=%0d want v=1 rd=4", bus.exValid, bus.exRd); else n_pass++;
    n_total++; if (bus.exRs1Val !== 32'h11 || bus.exRs2Val !== 32'h11) $display("FAIL raw_byp_ops: got %h,%h want 11,11", bus.exRs1Val, bus.exRs2Val); else n_pass++;
    @(negedge clk); set_wb(1'b0, '0, '0); idle(); tick();
`else
    n_total++; if (bus.ifReady !== 1'b0) $display("FAIL raw_wb_stall: got %0b want 0", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b0) $display("FAIL raw_wb_bubble: got %0b want 0", bus.exValid); else n_pass++;
    @(negedge clk); set_wb(1'b0, '0, '0); #1;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL raw_release: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b1 || bus.exRd !== 5'd4) $display("FAIL raw_issue: got v=%0b rd=%0d want v=1 rd=4", bus.exValid, bus.exRd); else n_pass++;
    n_total++; if (bus.exRs1Val !== 32'h11 || bus.exRs2Val !== 32'h11) $display("FAIL raw_ops: got %h,%h want 11,11", bus.exRs1Val, bus.exRs2Val); else n_pass++;
    @(negedge clk); idle(); tick();
`endif
    retire(5'd4, 32'h22);
  endtask

  task automatic test_backpressure();
    @(negedge clk); bus.exReady = 1'b0; drive(32'h00500093, 32'h300); tick();
    n_total++; if (bus.exValid !== 1'b1) $display("FAIL bp_load: got %0b want 1", bus.exValid); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive(32'h00700113, 32'h304); #1;
      n_total++; if (bus.ifReady !== 1'b0) $display("FAIL bp_ready%0d: got %0b want 0", c, bus.ifReady); else n_pass++;
      tick();
      n_total++; if (bus.exValid !== 1'b1 || bus.exPc !== 32'h300 || bus.exImm !== 32'd5)
        $display("FAIL bp_hold%0d: got v=%0b pc=%h imm=%h want 1 300 5", c, bus.exValid, bus.exPc, bus.exImm); else n_pass++;
    end
    @(negedge clk); bus.exReady = 1'b1; #1;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL bp_resume: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exPc !== 32'h304 || bus.exImm !== 32'd7) $display("FAIL bp_next: got pc=%h imm=%h want 304 7", bus.exPc, bus.exImm); else n_pass++;
    @(negedge clk); idle(); tick();
    retire(5'd1, 32'd5);
    retire(5'd2, 32'd7);
  endtask

  task automatic test_flush();
    @(negedge clk); bus.exReady = 1'b0; drive(32'h00002283, 32'h400); tick();
    n_total++; if (bus.exValid !== 1'b1 || bus.exMemRead !== 1'b1 || bus.exRd !== 5'd5)
      $display("FAIL fl_lw: got v=%0b mr=%0b rd=%0d want 1 1 5", bus.exValid, bus.exMemRead, bus.exRd); else n_pass++;
    @(negedge clk); idle(); bus.flush = 1'b1; tick();
    n_total++; if (bus.exValid !== 1'b0) $display("FAIL fl_valid: got %0b want 0", bus.exValid); else n_pass++;
    @(negedge clk); bus.flush = 1'b0; bus.exReady = 1'b1; drive(32'h00028333, 32'h404); #1;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL fl_nostall: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b1 || bus.exRd !== 5'd6) $display("FAIL fl_add: got v=%0b rd=%0d want 1 6", bus.exValid, bus.exRd); else n_pass++;
    @(negedge clk); bus.flush = 1'b1; drive(32'h00500093, 32'h408); tick();
    n_total++; if (bus.exValid !== 1'b0) $display("FAIL fl_drop: got %0b want 0", bus.exValid); else n_pass++;
    @(negedge clk); bus.flush = 1'b0; drive(32'h001303B3, 32'h40C); #1;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL fl_nopend: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b1 || bus.exPc !== 32'h40C) $display("FAIL fl_after: got v=%0b pc=%h want 1 40c", bus.exValid, bus.exPc); else n_pass++;
    @(negedge clk); idle(); tick();
    retire(5'd7, 32'h77);
  endtask

  task automatic test_x0();
    @(negedge clk); drive(32'h00208033, 32'h500); tick();
    n_total++; if (bus.exValid !== 1'b1 || bus.exRegWrite !== 1'b0) $display("FAIL x0_we: got v=%0b we=%0b want 1 0", bus.exValid, bus.exRegWrite); else n_pass++;
    @(negedge clk); drive(32'h000003B3, 32'h504); #1;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL x0_nopend: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exRs1Val !== 32'h0 || bus.exRs2Val !== 32'h0) $display("FAIL x0_read: got %h,%h want 0,0", bus.exRs1Val, bus.exRs2Val); else n_pass++;
    @(negedge clk); idle(); tick();
    retire(5'd7, 32'h0);
  endtask

  task automatic test_imm();
    logic [31:0] instr [5];
    logic [31:0] exp_imm [5];
    logic        exp_we [5];
    instr[0] = 32'hFE002E23; exp_imm[0] = 32'hFFFFFFFC; exp_we[0] = 1'b0; // sw x0,-4(x0)
    instr[1] = 32'hFE000EE3; exp_imm[1] = 32'hFFFFFFFC; exp_we[1] = 1'b0; // beq x0,x0,-4
    instr[2] = 32'h0010006F; exp_imm[2] = 32'h00000800; exp_we[2] = 1'b0; // jal x0,+2048
    instr[3] = 32'hABCDE437; exp_imm[3] = 32'hABCDE000; exp_we[3] = 1'b1; // lui x8,0xABCDE
    instr[4] = 32'hFFFFFFFF; exp_imm[4] = 32'h00000000; exp_we[4] = 1'b0; // unknown opcode
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive(instr[k], 32'h700 + 32'(4 * k)); tick();
      n_total++; if (bus.exValid !== 1'b1 || bus.exImm !== exp_imm[k])
        $display("FAIL imm%0d: got v=%0b imm=%h want 1 %h", k, bus.exValid, bus.exImm, exp_imm[k]); else n_pass++;
      n_total++; if (bus.exRegWrite !== exp_we[k]) $display("FAIL imm_we%0d: got %0b want %0b", k, bus.exRegWrite, exp_we[k]); else n_pass++;
    end
    n_total++; if (bus.exOpcode !== 7'h7F || bus.exFunct3 !== 3'd7 || bus.exFunct7b5 !== 1'b1 || bus.exMemRead !== 1'b0)
      $display("FAIL imm_unknown: got op=%h f3=%0d f7b5=%0b mr=%0b want 7f 7 1 0", bus.exOpcode, bus.exFunct3, bus.exFunct7b5, bus.exMemRead); else n_pass++;
    @(negedge clk); idle(); tick();
    retire(5'd8, 32'hABCDE000);
  endtask

  task automatic test_reset_midop();
    @(negedge clk); drive(32'h00100493, 32'h800); tick();
    n_total++; if (bus.exValid !== 1'b1) $display("FAIL mid_load: got %0b want 1", bus.exValid); else n_pass++;
    @(negedge clk); idle(); #2 rst_n = 1'b0; #1;
    n_total++; if (bus.exValid !== 1'b0) $display("FAIL mid_async: got %0b want 0", bus.exValid); else n_pass++;
    @(negedge clk); rst_n = 1'b1; drive(32'h00048533, 32'h804); #1;
    n_total++; if (bus.ifReady !== 1'b1) $display("FAIL mid_pend: got %0b want 1", bus.ifReady); else n_pass++;
    tick();
    n_total++; if (bus.exValid !== 1'b1 || bus.exRd !== 5'd10) $display("FAIL mid_issue: got v=%0b rd=%0d want 1 10", bus.exValid, bus.exRd); else n_pass++;
    @(negedge clk); idle(); tick();
    retire(5'd10, 32'h0);
  endtask

  initial begin
    idle(); set_wb(1'b0, '0, '0); bus.flush = 1'b0; bus.exReady = 1'b1;
    test_reset();
    test_back_to_back();
    test_raw();
    test_backpressure();
    test_flush();
    test_x0();
    test_imm();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
